main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_resp_pipe.sv | 35 +++
 rtl/main_mem_responder.sv | 100 ++++++++++
 tb/tb_main_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, default latency and the response pipeline entry for the memory responder.
// Optional macro MEM_RESP_ADDR_ECHO_EN adds the echoed read address to each entry.
package mem_pkg;

    localparam int MEM_WORD_W          = 16;
    localparam int MEM_ADDR_W          = 16;
    localparam int MEM_DEFAULT_LATENCY = 4;

    typedef struct packed {
        logic                  valid;
`ifdef MEM_RESP_ADDR_ECHO_EN
        logic [MEM_ADDR_W-1:0] addr;
`endif
        logic [MEM_WORD_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth delay line; a synchronous clear zeroes every stage in one edge.
module mem_resp_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_q;
            logic [WIDTH-1:0] stage_d;

            if (gi == 0) begin : g_head
                assign stage_d = d_i;
            end else begin : g_body
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk) begin
                if (clr_i) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency 16-bit memory responder: reads sampled at issue, returned LATENCY cycles later.
// Optional macro MEM_RESP_ADDR_ECHO_EN adds output data_addr aligned with data_valid.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = MEM_DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_WORD_W-1:0] data_in,
    output logic [MEM_WORD_W-1:0] data_out,
    output logic                  data_valid
`ifdef MEM_RESP_ADDR_ECHO_EN
    ,
    output logic [MEM_ADDR_W-1:0] data_addr
`endif
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [MEM_WORD_W-1:0] mem_q [WORDS];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  wr_en;
    logic                  rd_valid_d;
    logic                  rd_valid_q;
    logic [MEM_WORD_W-1:0] rd_data_q;
    logic                  unused_addr_bits;
    resp_t                 pipe_in;
    resp_t                 pipe_out;

    // Byte address: bit 0 and bits above the depth are dropped, so addresses wrap.
    assign word_idx         = addr[DEPTH_LOG2:1];
    assign unused_addr_bits = ^addr;
    assign wr_en            = enable & wr & ~rst;
    assign rd_valid_d       = enable & ~wr & ~rst;

    // Storage and its registered read port; the read register is the first latency stage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= data_in;
        end
        if (rd_valid_d) begin
            rd_data_q <= mem_q[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef MEM_RESP_ADDR_ECHO_EN
    logic [MEM_ADDR_W-1:0] rd_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if (rd_valid_d) begin
            rd_addr_q <= addr;
        end
    end
`endif

    // Bubbles enter the pipe as all-zero entries.
    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = rd_valid_q;
        if (rd_valid_q) begin
            pipe_in.data = rd_data_q;
`ifdef MEM_RESP_ADDR_ECHO_EN
            pipe_in.addr = rd_addr_q;
`endif
        end
    end

    // Remaining LATENCY-1 stages; LATENCY must be at least 2.
    mem_resp_pipe #(
        .DEPTH (LATENCY - 1),
        .WIDTH ($bits(resp_t))
    ) u_pipe (
        .clk   (clk),
        .clr_i (rst),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign data_valid = pipe_out.valid;
    assign data_out   = pipe_out.valid ? pipe_out.data : '0;
`ifdef MEM_RESP_ADDR_ECHO_EN
    assign data_addr  = pipe_out.valid ? pipe_out.addr : '0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed scoreboard bench for main_mem_responder; expected reads queued at issue, checked on return.
module tb_main_mem_responder;
    import mem_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
`ifdef MEM_RESP_ADDR_ECHO_EN
    logic [15:0] data_addr;
`endif

    always #5 clk = ~clk;

    main_mem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid)
`ifdef MEM_RESP_ADDR_ECHO_EN
        ,
        .data_addr  (data_addr)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_mem [int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    bit          mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are accepted at the next one.
    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input bit track = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        if (en && !rst) begin
            if (w) begin
                model_mem[int'(a[15:1])] = d;
            end else if (track) begin
                e.data = model_mem.exists(int'(a[15:1])) ? model_mem[int'(a[15:1])] : 16'hxxxx;
                e.addr = a;
                e.due  = cyc + LAT;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            enable  = 1'b0;
            wr      = 1'b0;
            addr    = 16'h0;
            data_in = 16'h0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (data_valid === 1'b1) begin
                exp_t e;
                n_cmp++;
                assert (sb_q.size() > 0) else begin
                    n_mis++;
                    $error("FAIL unexpected_valid: observed valid data %h expected no response at cycle %0d",
                           data_out, cyc);
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    $display("resp cyc=%0d data=%h", cyc, data_out);
                    chk("rd_data", 32'(data_out), 32'(e.data));
                    chk("rd_cycle", cyc, e.due);
`ifdef MEM_RESP_ADDR_ECHO_EN
                    chk("rd_addr", 32'(data_addr), 32'(e.addr));
`endif
                end
            end else begin
                chk("idle_valid", 32'(data_valid), 32'h0);
                chk("idle_data", 32'(data_out), 32'h0);
`ifdef MEM_RESP_ADDR_ECHO_EN
                chk("idle_addr", 32'(data_addr), 32'h0);
`endif
                if (sb_q.size() > 0) begin
                    n_cmp++;
                    assert (sb_q[0].due > cyc) else begin
                        n_mis++;
                        $error("FAIL missing_resp: observed no valid expected data %h at cycle %0d",
                               sb_q[0].data, sb_q[0].due);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(data_valid), 32'h0);
        chk("reset_data", 32'(data_out), 32'h0);
        mon_on = 1'b1;

        // Write then read the same word on the next cycle.
        drive(1'b1, 1'b1, 16'h0010, 16'h1234);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(LAT + 2);

        // Preload then eight back-to-back reads.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0000);
        idle(LAT + 2);

        // Read-at-issue: a write right after a read does not alter the in-flight result.
        drive(1'b1, 1'b1, 16'h0020, 16'h5555);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b1, 16'h0020, 16'hAAAA);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(LAT + 2);

        // Read, bubble, read; the idle monitor checks the zero slot between them.
        drive(1'b1, 1'b1, 16'h0030, 16'h1111);
        drive(1'b1, 1'b1, 16'h0032, 16'h2222);
        drive(1'b1, 1'b0, 16'h0030, 16'h0000);
        drive(1'b0, 1'b1, 16'h0032, 16'hFFFF);
        drive(1'b1, 1'b0, 16'h0032, 16'h0000);
        idle(LAT + 2);

        // addr[0] is ignored; also the address-echo case.
        drive(1'b1, 1'b1, 16'h0042, 16'hBEEF);
        drive(1'b1, 1'b0, 16'h0043, 16'h0000);
        idle(2);
        drive(1'b1, 1'b0, 16'h0042, 16'h0000);
        idle(LAT + 2);

        // In-flight reads discarded by reset; enable during reset must not write.
        drive(1'b1, 1'b1, 16'h0050, 16'h7777);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0050;
        data_in = 16'hDEAD;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b0;
        idle(LAT + 4);

        // Memory survives reset.
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h0050, 16'h0000);
        drive(1'b1, 1'b0, 16'h010E, 16'h0000);
        idle(LAT + 3);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
